touch_packet_decoder: RTL and testbench

Receives the resistive-touchscreen controller's serial stream on the touch UART pin (GPIO_1[31]) and turns it into decoded touch events. Each event carries pen state and 12-bit X/Y coordinates, and is presented on a valid/ready interface to the downstream whiteboard logic (the Avalon slave or FIFO feeding the HPS). The block contains an 8N1 UART receiver and a 5-byte packet parser with resynchronisation. It holds one completed event while downstream is stalled.

---
 rtl/touch_pkg.sv | 33 +++
 rtl/touch_uart_rx.sv | 77 +++++++
 rtl/touch_packet_decoder.sv | 127 ++++++++++++
 tb/tb_touch_packet_decoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// Shared types and constants for the touchscreen packet decoder.
package touch_pkg;

    localparam logic [7:0] HDR_PEN_UP   = 8'h80;
    localparam logic [7:0] HDR_PEN_DOWN = 8'h81;
    localparam int         COORD_W      = 12;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_XLO,
        ST_XHI,
        ST_YLO,
        ST_YHI
    } parse_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic               pen;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } touch_evt_t;

    function automatic logic is_header(input logic [7:0] b);
        return (b == HDR_PEN_UP) || (b == HDR_PEN_DOWN);
    endfunction

endpackage

// File: rtl/touch_uart_rx.sv
// 8N1 UART receiver with a 2-FF input synchroniser; emits one-cycle
// byte_valid or byte_ferr pulses at the stop-bit sample point.
module touch_uart_rx
    import touch_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_ferr
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic             meta_q, sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             cnt_done;

    // START waits half a bit so every later sample lands mid-bit.
    assign cnt_done = (state_q == RX_START) ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= RX_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (!sync_q) state_d = RX_START;
            RX_START: if (cnt_done) state_d = sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_done && bit_q == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (cnt_done) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        byte_ferr  = 1'b0;
        if (state_q == RX_STOP && cnt_done) begin
            byte_valid = sync_q;
            byte_ferr  = !sync_q;
        end
    end

    assign byte_data = shift_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            cnt_q  <= '0;
            bit_q  <= '0;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
            if (state_q == RX_IDLE || cnt_done) cnt_q <= '0;
            else                                cnt_q <= cnt_q + 1'b1;
            if (state_q == RX_START)                 bit_q <= '0;
            else if (state_q == RX_DATA && cnt_done) bit_q <= bit_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == RX_DATA && cnt_done) shift_q <= {sync_q, shift_q[7:1]};
    end

endmodule

// File: rtl/touch_packet_decoder.sv
// Touchscreen stream decoder: UART bytes -> 5-byte packet parser with
// resynchronisation -> one-deep valid/ready event holding register.
module touch_packet_decoder
    import touch_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rxd,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic               evt_pen,
    output logic [COORD_W-1:0] evt_x,
    output logic [COORD_W-1:0] evt_y,
    output logic               overflow,
    output logic               proto_err,
    input  logic               err_clr
);

    logic       byte_valid, byte_ferr;
    logic [7:0] byte_data;

    touch_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ferr  (byte_ferr)
    );

    parse_state_e state_q, state_d;
    logic         pen_q, pen_d;
    logic [6:0]   xlo_q, xlo_d, ylo_q, ylo_d;
    logic [4:0]   xhi_q, xhi_d;
    logic         hdr_byte, commit, proto_set;
    touch_evt_t   evt_q, evt_d;
    logic         valid_q, ovf_q, perr_q;

    assign hdr_byte = is_header(byte_data);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_HDR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (byte_ferr) begin
            state_d = ST_HDR;
        end else if (byte_valid) begin
            if (state_q == ST_HDR) begin
                if (hdr_byte) state_d = ST_XLO;
            end else if (byte_data[7]) begin
                state_d = hdr_byte ? ST_XLO : ST_HDR;
            end else begin
                case (state_q)
                    ST_XLO:  state_d = ST_XHI;
                    ST_XHI:  state_d = ST_YLO;
                    ST_YLO:  state_d = ST_YHI;
                    default: state_d = ST_HDR;
                endcase
            end
        end
    end

    // A header byte latches pen whether it starts a packet or resyncs one.
    always_comb begin
        pen_d     = pen_q;
        xlo_d     = xlo_q;
        xhi_d     = xhi_q;
        ylo_d     = ylo_q;
        commit    = 1'b0;
        proto_set = byte_ferr;
        if (byte_valid) begin
            if (hdr_byte) pen_d = byte_data[0];
            if (state_q != ST_HDR && byte_data[7]) proto_set = 1'b1;
            if (!byte_data[7]) begin
                case (state_q)
                    ST_XLO:  xlo_d  = byte_data[6:0];
                    ST_XHI:  xhi_d  = byte_data[4:0];
                    ST_YLO:  ylo_d  = byte_data[6:0];
                    ST_YHI:  commit = 1'b1;
                    default: ;
                endcase
            end
        end
        evt_d = {pen_q, xhi_q, xlo_q, byte_data[4:0], ylo_q};
    end

    always_ff @(posedge clk) begin
        pen_q <= pen_d;
        xlo_q <= xlo_d;
        xhi_q <= xhi_d;
        ylo_q <= ylo_d;
    end

    // Accepting and loading in the same cycle keeps valid high without loss.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            evt_q   <= '0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            if (commit && (!valid_q || evt_ready)) begin
                valid_q <= 1'b1;
                evt_q   <= evt_d;
            end else if (valid_q && evt_ready) begin
                valid_q <= 1'b0;
            end
            if (commit && valid_q && !evt_ready) ovf_q <= 1'b1;
            else if (err_clr)                    ovf_q <= 1'b0;
            if (proto_set)    perr_q <= 1'b1;
            else if (err_clr) perr_q <= 1'b0;
        end
    end

    assign evt_valid = valid_q;
    assign evt_pen   = evt_q.pen;
    assign evt_x     = evt_q.x;
    assign evt_y     = evt_q.y;
    assign overflow  = ovf_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_touch_packet_decoder.sv
// Directed bench for touch_packet_decoder: serial stimulus with a queue of
// expected events that is popped whenever an event transfers.
module tb_touch_packet_decoder;
    import touch_pkg::*;

    localparam int CPB = 16;
    localparam int GAP = 24;

    logic               clk = 1'b0;
    logic               reset, rxd, evt_ready, err_clr;
    logic               evt_valid, evt_pen, overflow, proto_err;
    logic [COORD_W-1:0] evt_x, evt_y;

    int         checks = 0;
    int         failures = 0;
    int         nbytes = 0;
    int         nb_snap;
    bit         seen;
    touch_evt_t exp_q[$];
    touch_evt_t mon_e;

    always #5 clk = ~clk;

    touch_packet_decoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_pen   (evt_pen),
        .evt_x     (evt_x),
        .evt_y     (evt_y),
        .overflow  (overflow),
        .proto_err (proto_err),
        .err_clr   (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic touch_evt_t mk(input logic pen, input logic [11:0] x, input logic [11:0] y);
        return {pen, x, y};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic v, input int n);
        rxd = v;
        tick(n);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop, CPB);
        hold(1'b1, GAP);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
        send_byte(b4, 1'b1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd0);
        chk({tag, "_pen"},   32'(evt_pen),   32'd0);
        chk({tag, "_x"},     32'(evt_x),     32'd0);
        chk({tag, "_y"},     32'(evt_y),     32'd0);
        chk({tag, "_ovf"},   32'(overflow),  32'd0);
        chk({tag, "_perr"},  32'(proto_err), 32'd0);
    endtask

    // Event monitor samples mid-cycle, well clear of both clock edges.
    always @(negedge clk) begin
        if (dut.byte_valid === 1'b1) nbytes++;
        #2;
        if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_event observed=0x%0h expected=none", {evt_pen, evt_x, evt_y});
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("event", 32'({evt_pen, evt_x, evt_y}), 32'(mon_e));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        rxd       = 1'b1;
        evt_ready = 1'b1;
        err_clr   = 1'b0;
        @(posedge clk);
        #1;
        tick(4);
        chk_reset_vals("por");
        reset = 1'b0;
        tick(4);

        // Pen-down packet
        exp_q.push_back(mk(1'b1, 12'h790, 12'h3A0));
        send_pkt(8'h81, 8'h10, 8'h0F, 8'h20, 8'h07);
        chk("t1_drain", 32'(exp_q.size()), 32'd0);
        chk("t1_ovf",   32'(overflow),     32'd0);
        chk("t1_perr",  32'(proto_err),    32'd0);

        // Overflow: second packet dropped while the first is held
        evt_ready = 1'b0;
        exp_q.push_back(mk(1'b0, 12'h001, 12'h002));
        send_pkt(8'h80, 8'h01, 8'h00, 8'h02, 8'h00);
        send_pkt(8'h81, 8'h7F, 8'h1F, 8'h7F, 8'h1F);
        chk("t2_valid", 32'(evt_valid), 32'd1);
        chk("t2_pen",   32'(evt_pen),   32'd0);
        chk("t2_x",     32'(evt_x),     32'h001);
        chk("t2_y",     32'(evt_y),     32'h002);
        chk("t2_ovf",   32'(overflow),  32'd1);
        evt_ready = 1'b1;
        tick(2);
        chk("t2_drain", 32'(exp_q.size()), 32'd0);
        chk("t2_valid_after", 32'(evt_valid), 32'd0);
        pulse_clr();
        chk("t2_ovf_clr", 32'(overflow), 32'd0);

        // Header inside a data state resynchronises
        send_byte(8'h81, 1'b1);
        send_byte(8'h05, 1'b1);
        exp_q.push_back(mk(1'b0, 12'h003, 12'h004));
        send_pkt(8'h80, 8'h03, 8'h00, 8'h04, 8'h00);
        chk("t3_perr",  32'(proto_err),    32'd1);
        chk("t3_drain", 32'(exp_q.size()), 32'd0);
        pulse_clr();
        chk("t3_perr_clr", 32'(proto_err), 32'd0);

        // Framing error discards the partial packet
        send_byte(8'h81, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h55, 1'b0);
        chk("t4_perr_ferr", 32'(proto_err), 32'd1);
        exp_q.push_back(mk(1'b0, 12'h111, 12'h1A2));
        send_pkt(8'h80, 8'h11, 8'h02, 8'h22, 8'h03);
        chk("t4_drain", 32'(exp_q.size()), 32'd0);
        pulse_clr();

        // Start-bit glitch
        nb_snap = nbytes;
        hold(1'b0, 4);
        hold(1'b1, 3 * CPB);
        chk("glitch_bytes", 32'(nbytes - nb_snap), 32'd0);
        chk("glitch_perr",  32'(proto_err),        32'd0);
        chk("glitch_ovf",   32'(overflow),         32'd0);

        // Reset mid YLO byte with an event held and proto_err set
        evt_ready = 1'b0;
        send_pkt(8'h81, 8'h10, 8'h0F, 8'h20, 8'h07);
        send_byte(8'h81, 1'b1);
        send_byte(8'hC0, 1'b1);
        send_byte(8'h81, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h0F, 1'b1);
        chk("rst_pre_valid", 32'(evt_valid), 32'd1);
        chk("rst_pre_perr",  32'(proto_err), 32'd1);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        reset = 1'b1;
        rxd   = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk_reset_vals("midrst");
        evt_ready = 1'b1;
        tick(GAP);
        exp_q.push_back(mk(1'b1, 12'hAAA, 12'h4B3));
        send_pkt(8'h81, 8'h2A, 8'h75, 8'h33, 8'h09);
        chk("rst_drain", 32'(exp_q.size()), 32'd0);

        // Accept of the held event in the exact commit cycle of the next
        evt_ready = 1'b0;
        exp_q.push_back(mk(1'b0, 12'h1C4, 12'h0D5));
        send_pkt(8'h80, 8'h44, 8'h03, 8'h55, 8'h01);
        chk("sim_first_held", 32'(evt_valid), 32'd1);
        exp_q.push_back(mk(1'b1, 12'h081, 12'h081));
        send_byte(8'h81, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        seen = 1'b0;
        fork
            send_byte(8'h01, 1'b1);
            begin
                for (int n = 0; n < 400 && !seen; n++) begin
                    @(negedge clk);
                    seen = (dut.byte_valid === 1'b1);
                end
                if (seen) begin
                    evt_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    evt_ready = 1'b0;
                end
            end
        join
        chk("sim_commit_seen", 32'(seen),         32'd1);
        chk("sim_valid",       32'(evt_valid),    32'd1);
        chk("sim_ovf",         32'(overflow),     32'd0);
        chk("sim_pending",     32'(exp_q.size()), 32'd1);
        chk("sim_second_x",    32'(evt_x),        32'h081);
        evt_ready = 1'b1;
        tick(2);
        chk("sim_drain", 32'(exp_q.size()), 32'd0);
        chk("sim_valid_after", 32'(evt_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
